// File: rtl/risc_v_mike_lsu.sv
// Load/store unit: byte-addressed requests to word memory, RMW for sub-word stores.
// Optional macro RISC_V_MIKE_LSU_MISALIGN_TRAP_EN turns misaligned H/W accesses into errors.
module risc_v_mike_lsu #(
  parameter int unsigned DATA_MEM_DEPTH = 16,
  parameter int unsigned MEM_ADDR_W     = $clog2(DATA_MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic                  mem_write,
  output logic [31:0]           mem_wr_data,
  input  logic [31:0]           mem_rd_data
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_STORE     = 3'd2;
  localparam logic [2:0] S_RMW_READ  = 3'd3;
  localparam logic [2:0] S_RMW_WRITE = 3'd4;
  localparam logic [2:0] S_RESP      = 3'd5;

  localparam logic [29:0] DEPTH_L = 30'(DATA_MEM_DEPTH);

  logic [2:0]            state_q,     state_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q,   rsp_err_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic [MEM_ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic                  mem_write_q, mem_write_d;
  logic [31:0]           merge_q,     merge_d;
  logic [2:0]            funct3_q,    funct3_d;
  logic [1:0]            addr_lo_q,   addr_lo_d;
  logic [15:0]           wdata_q,     wdata_d;

  logic        illegal_c;
  logic        range_err_c;
  logic        misalign_c;
  logic        req_err_c;
  logic [7:0]  ld_byte_c;
  logic [15:0] ld_half_c;
  logic [31:0] ld_data_c;
  logic [31:0] merged_c;

  // Request validation, evaluated on the raw request in IDLE
  assign illegal_c   = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                       (req_funct3 == 3'b111) || (req_we && req_funct3[2]);
  assign range_err_c = (req_addr[31:2] >= DEPTH_L);
`ifdef RISC_V_MIKE_LSU_MISALIGN_TRAP_EN
  assign misalign_c  = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
`else
  assign misalign_c  = 1'b0;
`endif
  assign req_err_c   = illegal_c || range_err_c || misalign_c;

  // Lane extraction for loads and lane insertion for sub-word stores
  always_comb begin
    ld_byte_c = mem_rd_data[{addr_lo_q, 3'b000} +: 8];
    ld_half_c = mem_rd_data[{addr_lo_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  ld_data_c = {{24{ld_byte_c[7]}}, ld_byte_c};
      3'b100:  ld_data_c = {24'h0, ld_byte_c};
      3'b001:  ld_data_c = {{16{ld_half_c[15]}}, ld_half_c};
      3'b101:  ld_data_c = {16'h0, ld_half_c};
      default: ld_data_c = mem_rd_data;
    endcase
    merged_c = mem_rd_data;
    if (funct3_q[0]) begin
      merged_c[{addr_lo_q[1], 4'b0000} +: 16] = wdata_q;
    end else begin
      merged_c[{addr_lo_q, 3'b000} +: 8] = wdata_q[7:0];
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_write_d = 1'b0;
    merge_d     = merge_q;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    wdata_d     = wdata_q;
    case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          funct3_d    = req_funct3;
          addr_lo_d   = req_addr[1:0];
          wdata_d     = req_wdata[15:0];
          mem_addr_d  = req_addr[2 +: MEM_ADDR_W];
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b0;
          if (req_err_c) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (!req_we) begin
            state_d = S_LOAD;
          end else if (req_funct3[1]) begin
            state_d     = S_STORE;
            mem_write_d = 1'b1;
            merge_d     = req_wdata;
          end else begin
            state_d = S_RMW_READ;
          end
        end
      end
      S_LOAD: begin
        rsp_rdata_d = ld_data_c;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_STORE: begin
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RMW_READ: begin
        merge_d     = merged_c;
        mem_write_d = 1'b1;
        state_d     = S_RMW_WRITE;
      end
      S_RMW_WRITE: begin
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        req_ready_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
      mem_addr_q  <= '0;
      mem_write_q <= 1'b0;
      merge_q     <= 32'h0;
      funct3_q    <= 3'b000;
      addr_lo_q   <= 2'b00;
      wdata_q     <= 16'h0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_write_q <= mem_write_d;
      merge_q     <= merge_d;
      funct3_q    <= funct3_d;
      addr_lo_q   <= addr_lo_d;
      wdata_q     <= wdata_d;
    end
  end

  // Write strobe is masked by reset so a dropped operation never reaches memory
  assign mem_write   = mem_write_q & rst;
  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wr_data = merge_q;

endmodule

// File: tb/tb_risc_v_mike_lsu.sv
// Self-checking bench for risc_v_mike_lsu with an attached word memory and a
// behavioural reference model of memory contents and responses.
module tb_risc_v_mike_lsu;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] mem_addr;
  logic          mem_write;
  logic [31:0]   mem_wr_data;
  logic [31:0]   mem_rd_data;

  logic [31:0] ram [DEPTH];
  logic [31:0] model_mem [DEPTH];
  int          wr_count = 0;
  int          checks   = 0;
  int          errors   = 0;

  risc_v_mike_lsu #(.DATA_MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_addr(mem_addr), .mem_write(mem_write),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  // Attached data memory: combinational read, write on clock edge
  assign mem_rd_data = ram[mem_addr];
  always @(posedge clk) begin
    if (mem_write) begin
      ram[mem_addr] <= mem_wr_data;
      wr_count      <= wr_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, hold rsp_ready low for 'hold' cycles of response, compare to model
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int hold, input string tag);
    logic        e_err;
    logic [31:0] e_rdata;
    logic [31:0] word;
    logic [31:0] v;
    logic [31:0] mask;
    int          e_lat, e_wcyc, sh, t, lat, wcyc, w0;
    logic        overlap;
    logic [31:0] rd_seen;
    e_err = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2]) ||
            (addr[31:2] >= 30'(DEPTH));
`ifdef RISC_V_MIKE_LSU_MISALIGN_TRAP_EN
    if (((f3 == 3'd1) || (f3 == 3'd5)) && addr[0]) e_err = 1'b1;
    if ((f3 == 3'd2) && (addr[1:0] != 2'd0)) e_err = 1'b1;
`endif
    e_rdata = 32'h0;
    e_wcyc  = -1;
    word    = e_err ? 32'h0 : model_mem[int'(addr[31:2])];
    if (e_err) begin
      e_lat = 1;
    end else if (!we) begin
      e_lat = 2;
      if (f3 == 3'd2) begin
        e_rdata = word;
      end else if (f3[0] == 1'b0) begin
        sh = 8 * int'(addr[1:0]);
        v  = (word >> sh) & 32'hFF;
        if (f3 == 3'd0 && v[7]) v = v | 32'hFFFFFF00;
        e_rdata = v;
      end else begin
        sh = 16 * int'(addr[1]);
        v  = (word >> sh) & 32'hFFFF;
        if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF0000;
        e_rdata = v;
      end
    end else if (f3 == 3'd2) begin
      e_lat  = 2;
      e_wcyc = 1;
      word   = wd;
    end else begin
      e_lat  = 3;
      e_wcyc = 2;
      if (f3 == 3'd0) begin
        sh   = 8 * int'(addr[1:0]);
        mask = 32'hFF << sh;
      end else begin
        sh   = 16 * int'(addr[1]);
        mask = 32'hFFFF << sh;
      end
      word = (word & ~mask) | ((wd << sh) & mask);
    end

    t = 0;
    while (!req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check({tag, ".ready"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    rsp_ready  = (hold == 0);
    w0         = wr_count;
    wcyc       = -1;
    overlap    = 1'b0;
    lat        = 0;
    @(posedge clk);
    do begin
      @(negedge clk);
      lat++;
      req_valid = 1'b0;
      if (mem_write) begin
        wcyc = lat;
        if (rsp_valid) overlap = 1'b1;
      end
    end while (!rsp_valid && lat < 10);
    check({tag, ".lat"},   32'(lat), 32'(e_lat));
    check({tag, ".err"},   32'(rsp_err), 32'(e_err));
    check({tag, ".rdata"}, rsp_rdata, e_rdata);
    check({tag, ".wcyc"},  32'(wcyc), 32'(e_wcyc));
    check({tag, ".ovl"},   32'(overlap), 32'd0);
    rd_seen = rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ".hold_v"},  32'(rsp_valid), 32'd1);
      check({tag, ".hold_d"},  rsp_rdata, rd_seen);
      check({tag, ".hold_rr"}, 32'(req_ready), 32'd0);
      check({tag, ".hold_mw"}, 32'(mem_write), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, ".done_v"}, 32'(rsp_valid), 32'd0);
    check({tag, ".writes"}, 32'(wr_count - w0), (e_wcyc >= 0) ? 32'd1 : 32'd0);
    if (!e_err && we) model_mem[int'(addr[31:2])] = word;
  endtask

  initial begin
    int w0;
    logic [2:0]  f3;
    logic [31:0] a;
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    rsp_ready  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst.req_ready", 32'(req_ready), 32'd0);
    check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst.rsp_err",   32'(rsp_err), 32'd0);
    check("rst.mem_write", 32'(mem_write), 32'd0);
    check("rst.rsp_rdata", rsp_rdata, 32'h0);
    check("rst.mem_addr",  32'(mem_addr), 32'h0);
    check("rst.wr_data",   mem_wr_data, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("rst.ready_rise", 32'(req_ready), 32'd1);

    // Fill every word with known data
    for (int i = 0; i < DEPTH; i++) do_req(1'b1, 3'd2, 32'(4 * i), $urandom, 0, "init");

    do_req(1'b1, 3'd2, 32'h8, 32'hDEADBEEF, 0, "sw");
    check("sw.word2", ram[2], 32'hDEADBEEF);
    do_req(1'b0, 3'd0, 32'hB, 32'h0, 0, "lb");
    do_req(1'b0, 3'd4, 32'hB, 32'h0, 0, "lbu");
    do_req(1'b0, 3'd1, 32'hA, 32'h0, 0, "lh");
    do_req(1'b0, 3'd5, 32'hA, 32'h0, 0, "lhu");
    do_req(1'b1, 3'd0, 32'h9, 32'h55, 0, "sb");
    check("sb.word2", ram[2], 32'hDEAD55EF);
    do_req(1'b1, 3'd1, 32'hA, 32'h1234, 0, "sh");
    do_req(1'b0, 3'd2, 32'h8, 32'h0, 5, "bp");
    do_req(1'b0, 3'd3, 32'h8, 32'h0, 0, "f3_011");
    do_req(1'b1, 3'd4, 32'h8, 32'h77, 0, "st_f3u");
    do_req(1'b1, 3'd2, 32'h40, 32'hCAFEF00D, 0, "oor");
    do_req(1'b0, 3'd2, 32'h6, 32'h0, 0, "lw_mis");
    do_req(1'b0, 3'd1, 32'h7, 32'h0, 0, "lh_mis");

    // Reset while the sub-word write is pending
    w0 = wr_count;
    while (!req_ready) @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'd0;
    req_addr   = 32'h15;
    req_wdata  = 32'hA5;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    #1 check("rmw_rst.mw_now", 32'(mem_write), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rmw_rst.mw", 32'(mem_write), 32'd0);
    end
    check("rmw_rst.rr_low", 32'(req_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rmw_rst.ready", 32'(req_ready), 32'd1);
    check("rmw_rst.rsp_v", 32'(rsp_valid), 32'd0);
    check("rmw_rst.writes", 32'(wr_count - w0), 32'd0);
    check("rmw_rst.word5", ram[5], model_mem[5]);

    for (int n = 0; n < 150; n++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 71));
      do_req(1'($urandom_range(0, 1)), f3, a, $urandom, $urandom_range(0, 2), "rnd");
    end

    for (int i = 0; i < DEPTH; i++) check("final.mem", ram[i], model_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
